// File: rtl/apb_req_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared types and constants for the APB request bridge:
//               master FSM encoding, protection width and the packed widths
//               of the request/response words carried through the FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    // Master FSM encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_PROT_WIDTH  = 3;
    localparam int REQ_WRITE_WIDTH = 1;
    localparam int RSP_ERR_WIDTH   = 1;

    // Request word: write flag, address, data, strobes, protection
    function automatic int req_word_width(input int addr_w, input int data_w);
        return REQ_WRITE_WIDTH + addr_w + data_w + (data_w / 8) + APB_PROT_WIDTH;
    endfunction

    // Response word: read data plus error flag
    function automatic int rsp_word_width(input int data_w);
        return data_w + RSP_ERR_WIDTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_req_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_req_master_if
// Description : Request/response handshake and APB bus bundle for the
//               request master. 'master' is the view of apb_req_master,
//               'slave' is the view of the FIFOs and APB completer.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_req_master_if
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Request side (dst of the request FIFO)
    logic                      req_vld;
    logic                      req_rdy;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [STRB_WIDTH-1:0]     req_strb;
    logic [APB_PROT_WIDTH-1:0] req_prot;

    // Response side (src of the response FIFO)
    logic                      rsp_vld;
    logic                      rsp_rdy;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;

    // APB bus
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [STRB_WIDTH-1:0]     pstrb;
    logic [APB_PROT_WIDTH-1:0] pprot;
    logic                      pready;
    logic                      pslverr;
    logic [DATA_WIDTH-1:0]     prdata;

    modport master (
        input  req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
        output req_rdy,
        output rsp_vld, rsp_rdata, rsp_err,
        input  rsp_rdy,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        output req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  req_rdy,
        input  rsp_vld, rsp_rdata, rsp_err,
        output rsp_rdy,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );

endinterface
`default_nettype wire

// File: rtl/apb_req_master_wait_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Saturating ACCESS-phase wait-state counter. 'expired' is high
//               while the count equals TIMEOUT_CYCLES. Used only when the
//               APB_TIMEOUT_EN build option is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_LIMIT   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Count wait states, holding at the limit until cleared
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/apb_req_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_req_master
// Description : Single-clock APB3/APB4 master. Pulls one request word from
//               the request FIFO, runs it as a SETUP+ACCESS transfer and
//               pushes the read data / error flag into the response FIFO.
//               Build option APB_TIMEOUT_EN: abort ACCESS after
//               TIMEOUT_CYCLES wait states with an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_master
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic          dst_clk,
    input  wire logic          dst_rst,
    apb_req_master_if.master   bus
);

    apb_state_e                r_state;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [ADDR_WIDTH-1:0]     r_paddr;
    logic [DATA_WIDTH-1:0]     r_pwdata;
    logic [STRB_WIDTH-1:0]     r_pstrb;
    logic [APB_PROT_WIDTH-1:0] r_pprot;
    logic                      r_rsp_vld;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;

`ifdef APB_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;

    // Counter restarts in SETUP so it reads zero on the first ACCESS cycle
    assign w_timer_clear = (r_state == SETUP);
    assign w_timer_en    = (r_state == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (dst_clk),
        .rst     (dst_rst),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );
`endif

    // Ready only in IDLE; independent of req_vld so the FIFO can pop freely
    assign bus.req_rdy   = (r_state == IDLE) && !dst_rst;

    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;
    assign bus.pprot     = r_pprot;
    assign bus.rsp_vld   = r_rsp_vld;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Transfer sequencer: accept, SETUP, ACCESS (wait on pready), respond
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_vld) begin
                        r_pwrite  <= bus.req_write;
                        r_paddr   <= bus.req_addr;
                        r_pwdata  <= bus.req_wdata;
                        // Reads never drive byte strobes
                        r_pstrb   <= bus.req_write ? bus.req_strb : '0;
                        r_pprot   <= bus.req_prot;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_err   <= bus.pslverr;
                        r_rsp_vld   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (w_expired) begin
                        // Completer never answered: report an error, no data
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_vld   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
